// File: rtl/simon_key_sched_seq.sv
// simon_key_sched_seq: sequential Simon 32/64 key expansion, one round key per clock into a held key array
// Ports: clk, rst (sync, active-high), load (start strobe, sampled when not generating),
//        keytext (master key, [15:0]=k0 .. [63:48]=k3), busy (generating), key_valid (schedule complete),
//        key (packed [ROUNDS-1:0][WORD-1:0], key[i] is the round-(i+1) key)
module simon_key_sched_seq #(
    parameter int WORD = 16,
    parameter int ROUNDS = 32,
    parameter logic [61:0] Z_SEQ = 62'b11111010001001010110000111001101111101000100101011000011100110
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         load,
    input  logic [63:0]                  keytext,
    output logic                         busy,
    output logic                         key_valid,
    output logic [ROUNDS-1:0][WORD-1:0]  key
);
    localparam int IW = $clog2(ROUNDS);
    typedef enum logic [1:0] {IDLE, GEN, DONE} state_t;
    state_t state, state_n;
    logic [IW-1:0] idx;
    logic [WORD-1:0] r, a, t, nk;
    logic [5:0] zi;
    logic start;
    always_comb begin
        start = load && state != GEN;
        state_n = start ? GEN : (state == GEN && idx == IW'(ROUNDS - 1)) ? DONE : state;
        // z0 is written leftmost-first, so sequence position p lives at vector bit 61-p
        zi = 6'd61 - 6'(idx - IW'(4));
        r = key[idx - IW'(1)];
        a = {r[2:0], r[WORD-1:3]} ^ key[idx - IW'(3)];
        t = a ^ {a[0], a[WORD-1:1]};
        nk = ~key[idx - IW'(4)] ^ t ^ WORD'(Z_SEQ[zi]) ^ WORD'(3);
    end
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else state <= state_n;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            idx <= '0;
            key <= '0;
        end else if (start) begin
            key[3:0] <= keytext;
            idx <= IW'(4);
        end else if (state == GEN) begin
            key[idx] <= nk;
            idx <= idx + IW'(1);
        end
    end
    assign busy = state == GEN;
    assign key_valid = state == DONE;
endmodule

// File: tb/tb_simon_key_sched_seq.sv
// tb_simon_key_sched_seq: randomized and directed checks of the key schedule against a reference model
module tb_simon_key_sched_seq;
    localparam logic [61:0] Z = 62'b11111010001001010110000111001101111101000100101011000011100110;
    typedef logic [31:0][15:0] ks_t;
    logic clk = 0, rst = 1, load = 0;
    logic [63:0] keytext = '0;
    logic busy, key_valid;
    ks_t key;
    int tests = 0, fails = 0;
    always #5 clk = ~clk;
    simon_key_sched_seq dut (
        .clk(clk), .rst(rst), .load(load), .keytext(keytext),
        .busy(busy), .key_valid(key_valid), .key(key)
    );
    function automatic logic [15:0] ror(input logic [15:0] v, input int n);
        return (v >> n) | (v << (16 - n));
    endfunction
    function automatic logic [15:0] rol(input logic [15:0] v, input int n);
        return (v << n) | (v >> (16 - n));
    endfunction
    function automatic ks_t sched(input logic [63:0] kt);
        ks_t k;
        logic [15:0] t;
        k[3:0] = kt;
        for (int i = 4; i < 32; i++) begin
            t = ror(k[i-1], 3) ^ k[i-3];
            t = t ^ ror(t, 1);
            k[i] = ~k[i-4] ^ t ^ {15'b0, Z[61 - ((i - 4) % 62)]} ^ 16'h0003;
        end
        return k;
    endfunction
    function automatic logic [31:0] encrypt(input ks_t k, input logic [31:0] pt);
        logic [15:0] x, y, t;
        x = pt[31:16];
        y = pt[15:0];
        for (int i = 0; i < 32; i++) begin
            t = x;
            x = y ^ (rol(x, 1) & rol(x, 8)) ^ rol(x, 2) ^ k[i];
            y = t;
        end
        return {x, y};
    endfunction
    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask
    task automatic step;
        @(posedge clk);
        #1;
    endtask
    task automatic run(input logic [63:0] kt, input int pulse_at, input logic [63:0] kt2);
        ks_t m;
        m = sched(kt);
        load = 1;
        keytext = kt;
        step;
        load = 0;
        keytext = {$urandom, $urandom};
        check("load_k03", key[3:0], kt);
        check("load_busy", busy, 1);
        check("load_valid", key_valid, 0);
        for (int c = 1; c <= 28; c++) begin
            if (c == pulse_at) begin
                load = 1;
                keytext = kt2;
            end
            step;
            load = 0;
            if (c <= 2) check("gen_key", key[c+3], m[c+3]);
            if (c == 27) begin
                check("gen_valid", key_valid, 0);
                check("gen_busy", busy, 1);
            end
        end
        check("done_valid", key_valid, 1);
        check("done_busy", busy, 0);
        for (int i = 0; i < 32; i++) check("sched", key[i], m[i]);
        step;
        check("stable_valid", key_valid, 1);
        check("stable_keys", key, m);
    endtask
    initial begin
        logic [63:0] r1, r2;
        load = 1;
        keytext = {$urandom, $urandom};
        step;
        step;
        check("rst_load_busy", busy, 0);
        check("rst_load_valid", key_valid, 0);
        rst = 0;
        load = 0;
        repeat (5) step;
        check("idle_busy", busy, 0);
        check("idle_valid", key_valid, 0);
        check("idle_keys_zero", key == '0, 1);
        run(64'h1918_1110_0908_0100, 0, 0);
        check("golden_k4", key[4], 16'h71C3);
        check("golden_k5", key[5], 16'hB649);
        check("cipher", encrypt(key, 32'h6565_6877), 32'hC69B_E9BB);
        r1 = {$urandom, $urandom};
        r2 = {$urandom, $urandom};
        run(r1, 10, r2);
        run(64'h0, 0, 0);
        check("zero_k4", key[4], 16'hFFFD);
        repeat (3) run({$urandom, $urandom}, 0, 0);
        load = 1;
        keytext = {$urandom, $urandom};
        step;
        load = 0;
        repeat (14) step;
        check("mid_busy", busy, 1);
        rst = 1;
        step;
        rst = 0;
        check("abort_busy", busy, 0);
        check("abort_valid", key_valid, 0);
        check("abort_keys_zero", key == '0, 1);
        run({$urandom, $urandom}, 0, 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
